// File: rtl/prom_fetch.sv
// prom_fetch: instruction fetch unit between a CPU and a program ROM.
// Holds the last delivered word (CUR) and one sequentially prefetched word (PF),
// issues at most one outstanding ROM read, and flags a sticky error when the
// ROM fails to answer within TIMEOUT cycles.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   cpu_addr       instruction address requested by the CPU
//   cpu_req        CPU wants the word at cpu_addr this cycle
//   instruction    fetched word (NOP_WORD while instr_valid=0)
//   instr_valid    instruction holds the word for the current cpu_addr
//   mem_req        ROM read request, held until mem_ready
//   mem_addr       ROM read address, stable while mem_req=1
//   mem_ready      ROM accepts the request when mem_req=1
//   mem_rvalid     ROM read data valid
//   mem_rdata      ROM read data
//   fetch_err      sticky ROM timeout flag
module prom_fetch #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_req,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        fetch_err
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    // Wait counter runs 0..TIMEOUT-1; the last value without a response times out.
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          valid;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DREQ  = 3'd1,
        DWAIT = 3'd2,
        PREQ  = 3'd3,
        PWAIT = 3'd4,
        DRAIN = 3'd5
    } state_t;

    state_t        state;
    entry_t        cur;
    entry_t        pf;
    logic [AW-1:0] dem_addr;
    logic [CW-1:0] tmo_cnt;

    logic          hit_cur;
    logic          hit_pf;
    logic          miss;
    logic          new_miss;
    logic          accept;
    logic          in_wait;
    logic          timed_out;
    logic [AW-1:0] cur_next;

    // Lookup of the CPU request against both buffer entries.
    assign hit_cur   = cpu_req && cur.valid && (cur.addr == cpu_addr);
    assign hit_pf    = cpu_req && pf.valid && (pf.addr == cpu_addr) && !hit_cur;
    assign miss      = cpu_req && !hit_cur && !hit_pf;
    // A miss that redirects an in-flight demand fetch to another address.
    assign new_miss  = miss && (cpu_addr != dem_addr);
    assign accept    = mem_req && mem_ready;
    assign in_wait   = (state == DWAIT) || (state == PWAIT) || (state == DRAIN);
    assign timed_out = in_wait && !mem_rvalid && (tmo_cnt == TMO_LAST);
    // 16-bit add wraps FFFF -> 0000.
    assign cur_next  = cur.addr + AW'(1);

    // Fetch FSM, buffers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur         <= '0;
            pf          <= '0;
            dem_addr    <= '0;
            tmo_cnt     <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else if (timed_out) begin
            // ROM stopped answering: abandon everything and flag it.
            state       <= IDLE;
            cur.valid   <= 1'b0;
            pf.valid    <= 1'b0;
            tmo_cnt     <= '0;
            mem_req     <= 1'b0;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b1;
        end else begin
            // CPU side: serve hits immediately, blank the output on a miss.
            if (hit_cur) begin
                instruction <= cur.data;
                instr_valid <= 1'b1;
            end else if (hit_pf) begin
                cur         <= pf;
                pf.valid    <= 1'b0;
                instruction <= pf.data;
                instr_valid <= 1'b1;
            end else if (miss) begin
                instruction <= NOP_WORD;
                instr_valid <= 1'b0;
                pf.valid    <= 1'b0;
            end

            // Response timer spans the whole outstanding request, including DRAIN.
            if (in_wait) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end else begin
                tmo_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (miss) begin
                        dem_addr <= cpu_addr;
                        mem_req  <= 1'b1;
                        mem_addr <= cpu_addr;
                        state    <= DREQ;
                    end else if (cur.valid && !pf.valid) begin
                        mem_req  <= 1'b1;
                        mem_addr <= cur_next;
                        state    <= PREQ;
                    end
                end

                DREQ: begin
                    if (accept) begin
                        mem_req <= 1'b0;
                        if (new_miss) begin
                            // Old address already accepted; its data must be drained.
                            dem_addr <= cpu_addr;
                            state    <= DRAIN;
                        end else begin
                            state <= DWAIT;
                        end
                    end else if (new_miss) begin
                        dem_addr <= cpu_addr;
                        mem_addr <= cpu_addr;
                    end
                end

                DWAIT: begin
                    if (mem_rvalid) begin
                        if (new_miss) begin
                            // Response is for a stale target; go straight to the new one.
                            dem_addr <= cpu_addr;
                            mem_req  <= 1'b1;
                            mem_addr <= cpu_addr;
                            state    <= DREQ;
                        end else begin
                            cur         <= {dem_addr, mem_rdata, 1'b1};
                            instruction <= mem_rdata;
                            instr_valid <= 1'b1;
                            state       <= IDLE;
                        end
                    end else if (new_miss) begin
                        dem_addr <= cpu_addr;
                        state    <= DRAIN;
                    end
                end

                PREQ: begin
                    if (miss) begin
                        dem_addr <= cpu_addr;
                        if (accept) begin
                            // Prefetch accepted on this edge; it must be drained.
                            mem_req <= 1'b0;
                            state   <= DRAIN;
                        end else begin
                            mem_addr <= cpu_addr;
                            state    <= DREQ;
                        end
                    end else if (accept) begin
                        mem_req <= 1'b0;
                        state   <= PWAIT;
                    end
                end

                PWAIT: begin
                    if (miss) begin
                        dem_addr <= cpu_addr;
                        if (mem_rvalid) begin
                            mem_req  <= 1'b1;
                            mem_addr <= cpu_addr;
                            state    <= DREQ;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (mem_rvalid) begin
                        pf    <= {cur_next, mem_rdata, 1'b1};
                        state <= IDLE;
                    end
                end

                DRAIN: begin
                    if (new_miss) begin
                        dem_addr <= cpu_addr;
                    end
                    if (mem_rvalid) begin
                        mem_req  <= 1'b1;
                        mem_addr <= new_miss ? cpu_addr : dem_addr;
                        state    <= DREQ;
                    end
                end

                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prom_fetch.sv
// tb_prom_fetch: self-checking bench for prom_fetch.
// A ROM model answers accepted reads after a configurable latency; a CPU model
// pushes the expected word for every request into a scoreboard queue and pops
// it when instr_valid appears. Directed phases cover cold miss, sequential
// hit, branch during prefetch, address wrap, request hold, timeout and reset
// during a read; a short random phase follows.
module tb_prom_fetch;

    localparam logic [31:0] NOP = 32'hDEAD_BEEF;
    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_req;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready  = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata  = 32'h0;
    logic        fetch_err;

    always #5 clk = ~clk;

    prom_fetch #(
        .NOP_WORD (NOP),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_addr    (cpu_addr),
        .cpu_req     (cpu_req),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .fetch_err   (fetch_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ROM contents.
    function automatic logic [31:0] mdata(input logic [15:0] a);
        case (a)
            16'h0003: return 32'h0003080E;
            16'h0004: return 32'h0007100E;
            default:  return {a ^ 16'hA5A5, a};
        endcase
    endfunction

    // ROM model configuration (written by the stimulus only).
    int unsigned lat_cfg    = 2;     // 0 selects a random latency 1..3
    bit          hang       = 1'b0;  // accept but never answer
    bit          rand_ready = 1'b0;
    bit          ready_cfg  = 1'b1;

    // ROM model state (written by the model only).
    logic [15:0] acc_q[$];
    bit          pend = 1'b0;
    int unsigned pend_cnt;
    logic [15:0] pend_addr;

    // ROM: drives its inputs on the falling edge; a request seen here with
    // mem_ready=1 is accepted on the next rising edge.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0BAD_0BAD;
        if (pend) begin
            if (pend_cnt <= 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mdata(pend_addr);
                pend       = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cfg;
        if (!rst && mem_req && mem_ready) begin
            acc_q.push_back(mem_addr);
            if (!hang) begin
                pend      = 1'b1;
                pend_cnt  = (lat_cfg == 0) ? $urandom_range(1, 3) : lat_cfg;
                pend_addr = mem_addr;
            end
        end
    end

    logic [47:0] exp_q[$];
    int          acc_base;

    task automatic cpu_issue(input logic [15:0] a);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = a;
        exp_q.push_back({a, mdata(a)});
    endtask

    // Hold the request until the word arrives; lat=1 means served at N+1.
    task automatic cpu_wait(input string tag, output int lat);
        logic [47:0] e;
        bit          got;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                got = 1'b1;
                lat = k;
            end
        end
        cpu_req = 1'b0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 48'h0;
        if (!got) begin
            check({tag, "_wait"}, 32'(got), 32'd1);
        end else begin
            check({tag, "_data"}, instruction, e[31:0]);
        end
    endtask

    task automatic fetch(input string tag, input logic [15:0] a, output int lat);
        cpu_issue(a);
        cpu_wait(tag, lat);
    endtask

    task automatic wait_acc(input string tag, input int n);
        int k;
        k = 0;
        while (acc_q.size() < acc_base + n && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (acc_q.size() < acc_base + n) begin
            check({tag, "_acc_wait"}, 32'(acc_q.size() - acc_base), 32'(n));
        end
    endtask

    function automatic logic [15:0] acc_at(input int i);
        return (acc_q.size() > acc_base + i) ? acc_q[acc_base + i] : 16'hxxxx;
    endfunction

    initial begin
        int          l;
        int          first;
        bit          seen;
        logic [15:0] a;
        logic [15:0] prev;

        rst      = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_instruction", instruction, NOP);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        rst = 1'b0;

        // Cold miss, then automatic prefetch of the next word.
        acc_base = acc_q.size();
        fetch("cold", 16'h0003, l);
        check("cold_lat_gt1", 32'(l > 1), 32'd1);
        wait_acc("cold", 2);
        check("cold_mem_addr", 32'(acc_at(0)), 32'h0003);
        check("cold_pf_addr", 32'(acc_at(1)), 32'h0004);
        repeat (6) @(negedge clk);

        // Sequential hit on the prefetched word.
        acc_base = acc_q.size();
        fetch("seq", 16'h0004, l);
        check("seq_lat", 32'(l), 32'd1);
        wait_acc("seq", 1);
        check("seq_pf_addr", 32'(acc_at(0)), 32'h0005);
        repeat (6) @(negedge clk);

        // Branch while a prefetch is outstanding.
        lat_cfg  = 3;
        acc_base = acc_q.size();
        fetch("pf_hit5", 16'h0005, l);
        check("pf_hit5_lat", 32'(l), 32'd1);
        wait_acc("br_pf", 1);
        fetch("branch", 16'h0100, l);
        check("branch_lat_gt1", 32'(l > 1), 32'd1);
        wait_acc("branch", 3);
        check("branch_pf_addr", 32'(acc_at(0)), 32'h0006);
        check("branch_dem_addr", 32'(acc_at(1)), 32'h0100);
        check("branch_next_pf", 32'(acc_at(2)), 32'h0101);
        repeat (8) @(negedge clk);

        // Prefetch address wraps at the top of the address space.
        lat_cfg  = 1;
        acc_base = acc_q.size();
        fetch("wrap", 16'hFFFF, l);
        wait_acc("wrap", 2);
        check("wrap_dem_addr", 32'(acc_at(0)), 32'hFFFF);
        check("wrap_pf_addr", 32'(acc_at(1)), 32'h0000);
        repeat (6) @(negedge clk);
        fetch("wrap_hit", 16'h0000, l);
        check("wrap_hit_lat", 32'(l), 32'd1);
        repeat (8) @(negedge clk);

        // Request and address held while the ROM is not ready.
        ready_cfg = 1'b0;
        acc_base  = acc_q.size();
        cpu_issue(16'h0200);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_mem_req", 32'(mem_req), 32'd1);
            check("hold_mem_addr", 32'(mem_addr), 32'h0200);
        end
        check("hold_no_accept", 32'(acc_q.size() - acc_base), 32'd0);
        ready_cfg = 1'b1;
        cpu_wait("hold", l);
        repeat (8) @(negedge clk);

        // ROM never answers a demand read.
        hang     = 1'b1;
        acc_base = acc_q.size();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 16'h0300;
        first    = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) cpu_req = 1'b0;
            if (fetch_err === 1'b1 && first == 0) first = k;
        end
        check("tmo_cycle", 32'(first), 32'd6);
        check("tmo_fetch_err", 32'(fetch_err), 32'd1);
        check("tmo_mem_req", 32'(mem_req), 32'd0);
        check("tmo_instr_valid", 32'(instr_valid), 32'd0);
        check("tmo_instruction", instruction, NOP);
        check("tmo_one_request", 32'(acc_q.size() - acc_base), 32'd1);
        hang = 1'b0;

        // Reset clears the error; a reset in the middle of a read drops its data.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_fetch_err", 32'(fetch_err), 32'd0);
        lat_cfg  = 3;
        acc_base = acc_q.size();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 16'h0400;
        @(negedge clk);
        cpu_req = 1'b0;
        wait_acc("rstw", 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstw_instr_valid", 32'(instr_valid), 32'd0);
        check("rstw_instruction", instruction, NOP);
        check("rstw_mem_req", 32'(mem_req), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0) seen = 1'b1;
        end
        check("rstw_no_prefetch", 32'(seen), 32'd0);
        fetch("rstw_refetch", 16'h0400, l);
        check("rstw_refetch_lat_gt1", 32'(l > 1), 32'd1);

        // Random mix of sequential, repeated and branching fetches.
        lat_cfg    = 0;
        rand_ready = 1'b1;
        prev       = 16'h0400;
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = prev + 16'd1;
                2:       a = prev;
                default: a = 16'($urandom_range(16'h0800, 16'h08FF));
            endcase
            fetch("rand", a, l);
            prev = a;
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        rand_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("end_fetch_err", 32'(fetch_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
